dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data memory responder: combinational word port plus a latency-modelled 8-word block port.
// Optional DMEM_SUBWORD_WRITE_EN enables byte-granular word writes; otherwise word writes are full-width.
module dmem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int BLK_LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  data_address_2DM,
  input  logic         MemRead_2DM,
  input  logic         MemWrite_2DM,
  input  logic [31:0]  data_write_2DM,
  input  logic [1:0]   data_write_size_2DM,
  output logic [31:0]  data_read_fDM,
  input  logic         dBlkRead,
  input  logic         dBlkWrite,
  input  logic [255:0] block_write_2DM,
  output logic [255:0] block_read_fDM,
  output logic         block_read_fDM_valid,
  output logic         block_write_fDM_valid
);

  localparam int BLK_BITS = ADDR_BITS - 3;

  typedef enum logic [1:0] {IDLE, BUSY_RD, BUSY_WR, DONE} state_t;

  state_t               state;
  logic [7:0]           cnt;
  logic [BLK_BITS-1:0]  blk_addr;
  logic [255:0]         blk_data;
  logic [31:0]          mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] word_idx;
  logic [BLK_BITS-1:0]  req_blk;
  logic [31:0]          word_wdata;
  logic                 blk_commit;

  assign word_idx      = data_address_2DM[ADDR_BITS+1:2];
  assign req_blk       = data_address_2DM[ADDR_BITS+1:5];
  assign blk_commit    = (state == BUSY_WR) && (cnt == '0);
  assign data_read_fDM = MemRead_2DM ? mem[word_idx] : '0;

`ifdef DMEM_SUBWORD_WRITE_EN
  logic unused_addr_hi;
  assign unused_addr_hi = ^data_address_2DM[31:ADDR_BITS+2];

  // Read-modify-write merge: byte o takes the most significant of the low n data bytes.
  always_comb begin
    int unsigned o, n, src;
    word_wdata = mem[word_idx];
    o   = 32'(data_address_2DM[1:0]);
    n   = 32'(data_write_size_2DM);
    src = 0;
    if (n == 0) begin
      word_wdata = data_write_2DM;
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (b >= o && (b - o) < n) begin
          src = n - 1 - (b - o);
          word_wdata[31-8*b -: 8] = data_write_2DM[8*src +: 8];
        end
      end
    end
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_address_2DM[31:ADDR_BITS+2], data_address_2DM[1:0],
                              data_write_size_2DM};
  assign word_wdata = data_write_2DM;
`endif

  // Block commit is ordered after the word write so a same-edge word write loses.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (MemWrite_2DM)
        mem[word_idx] <= word_wdata;
      if (blk_commit)
        for (int unsigned i = 0; i < 8; i++)
          mem[{blk_addr, 3'(i)}] <= blk_data[255-32*i -: 32];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state                 <= IDLE;
      cnt                   <= '0;
      block_read_fDM        <= '0;
      block_read_fDM_valid  <= 1'b0;
      block_write_fDM_valid <= 1'b0;
    end else begin
      block_read_fDM_valid  <= 1'b0;
      block_write_fDM_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (dBlkWrite) begin
            blk_addr <= req_blk;
            blk_data <= block_write_2DM;
            cnt      <= 8'(BLK_LATENCY - 1);
            state    <= BUSY_WR;
          end else if (dBlkRead) begin
            blk_addr <= req_blk;
            cnt      <= 8'(BLK_LATENCY - 1);
            state    <= BUSY_RD;
          end
        end
        BUSY_RD: begin
          if (cnt != '0) begin
            cnt <= cnt - 8'd1;
          end else begin
            for (int unsigned i = 0; i < 8; i++)
              block_read_fDM[255-32*i -: 32] <= mem[{blk_addr, 3'(i)}];
            block_read_fDM_valid <= 1'b1;
            state                <= DONE;
          end
        end
        BUSY_WR: begin
          if (cnt != '0) begin
            cnt <= cnt - 8'd1;
          end else begin
            block_write_fDM_valid <= 1'b1;
            state                 <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
